// File: rtl/palette_pkg.sv
// Shared types and helpers for the runtime-writable colour palette.
// The default colour table is a gray ramp taken from the index high nibble.
package palette_pkg;

  localparam int PAL_ENTRIES = 256;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    DRAIN
  } pal_state_t;

  function automatic rgb12_t default_color(input logic [7:0] index);
    rgb12_t c;
    c.r = index[7:4];
    c.g = index[7:4];
    c.b = index[7:4];
    return c;
  endfunction

endpackage

// File: rtl/palette_if.sv
// Host-write, pixel-lookup and status bundle of the palette controller.
// The master side is the host/pixel pipeline; the slave side is palette_ctrl.
interface palette_if #(
  parameter int INDEX_W    = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic               vblank;
  logic               wr_valid;
  logic               wr_ready;
  logic [INDEX_W-1:0] wr_index;
  logic [11:0]        wr_rgb;
  logic               rd_valid;
  logic [INDEX_W-1:0] rd_index;
  logic               rgb_valid;
  logic [3:0]         red;
  logic [3:0]         green;
  logic [3:0]         blue;
  logic               init_busy;
  logic [LVL_W-1:0]   fifo_level;

  modport master (
    output vblank, wr_valid, wr_index, wr_rgb, rd_valid, rd_index,
    input  wr_ready, rgb_valid, red, green, blue, init_busy, fifo_level
  );

  modport slave (
    input  vblank, wr_valid, wr_index, wr_rgb, rd_valid, rd_index,
    output wr_ready, rgb_valid, red, green, blue, init_busy, fifo_level
  );
endinterface

// File: rtl/palette_wr_fifo.sv
// Small first-word-fall-through synchronous FIFO for host configuration writes.
// A push while full or a pop while empty is ignored.
module palette_wr_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 20
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [DATA_W-1:0]           din_i,
  output logic [DATA_W-1:0]           dout_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = FIFO_DEPTH[PTR_W:0];

  logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        level_q, level_d;
  logic [FIFO_DEPTH-1:0] entry_we;
  logic                  do_push, do_pop;

  assign full_o  = (level_q == DEPTH_L);
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = do_push && (wr_ptr_q == PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level counter alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_we[i]) mem_q[i] <= din_i;
    end
  end

endmodule

// File: rtl/palette_ctrl.sv
// Shared 12-bit colour palette: gray-ramp initialisation, host writes buffered
// and committed only during vertical blanking, 2-cycle pixel lookups every cycle.
module palette_ctrl
  import palette_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int INDEX_W    = 8
) (
  input  logic      clk,
  input  logic      srst,
  palette_if.slave  bus
);
  localparam int ENTRY_W = INDEX_W + 12;
  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] LVL_ONE = 1;

  pal_state_t         state_q;
  logic [INDEX_W-1:0] init_cnt_q;
  logic               init_busy_q;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic [ENTRY_W-1:0] fifo_dout;

  logic               tbl_we;
  logic [INDEX_W-1:0] tbl_waddr;
  rgb12_t             tbl_wdata;
  rgb12_t             pal_mem [2**INDEX_W];
  rgb12_t             rd_data_q;

  logic               rd_valid_q, rd_init_q, rgb_valid_q;
  rgb12_t             rgb_q;

  // Readiness looks only at the level before any same-cycle pop.
  assign bus.wr_ready = !fifo_full && (state_q != INIT);
  assign fifo_push    = bus.wr_valid && bus.wr_ready;
  assign fifo_pop     = (state_q == DRAIN) && bus.vblank && !fifo_empty;

  palette_wr_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (ENTRY_W)
  ) u_wr_fifo (
    .clk     (clk),
    .srst    (srst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   ({bus.wr_index, bus.wr_rgb}),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == '1) begin
            state_q     <= IDLE;
            init_busy_q <= 1'b0;
          end
        end
        IDLE: begin
          if (bus.vblank && !fifo_empty) state_q <= DRAIN;
        end
        DRAIN: begin
          // Leave on blanking end, or on the pop that empties the buffer.
          if (!bus.vblank || fifo_empty || (fifo_level == LVL_ONE && !fifo_push))
            state_q <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = fifo_dout[ENTRY_W-1:12];
    tbl_wdata = rgb12_t'(fifo_dout[11:0]);
    if (!srst) begin
      if (state_q == INIT) begin
        tbl_we    = 1'b1;
        tbl_waddr = init_cnt_q;
        tbl_wdata = default_color(8'(init_cnt_q));
      end else if (fifo_pop) begin
        tbl_we = 1'b1;
      end
    end
  end

  // Simple dual-port table; a same-address read returns the pre-write colour.
  always_ff @(posedge clk) begin
    if (tbl_we) pal_mem[tbl_waddr] <= tbl_wdata;
    rd_data_q <= pal_mem[bus.rd_index];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_valid_q  <= 1'b0;
      rd_init_q   <= 1'b0;
      rgb_valid_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      rd_valid_q  <= bus.rd_valid;
      rd_init_q   <= init_busy_q;
      rgb_valid_q <= rd_valid_q;
      rgb_q       <= rd_init_q ? rgb12_t'(12'h000) : rd_data_q;
    end
  end

  assign bus.rgb_valid  = rgb_valid_q;
  assign bus.red        = rgb_q.r;
  assign bus.green      = rgb_q.g;
  assign bus.blue       = rgb_q.b;
  assign bus.init_busy  = init_busy_q;
  assign bus.fifo_level = fifo_level;

endmodule
